// File: rtl/dbus_pkg.sv
// Shared widths, FSM encoding and byte-lane helper for the data-bus memory slave.
package dbus_pkg;
  localparam int STB_W  = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [STB_W-1:0]  stb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STB_W; b++)
      if (stb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction
endpackage

// File: rtl/dbus_mem_array.sv
// DEPTH x 16 storage with synchronous byte-lane writes; contents are never reset.
module dbus_mem_array
  import dbus_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [STB_W-1:0]  i_be,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdat,
  output logic [DATA_W-1:0] o_rdat
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= lane_merge(r_mem[i_idx], i_wdat, i_be);
  end

  assign o_rdat = r_mem[i_idx];
endmodule

// File: rtl/dbus_mem.sv
// Wait-stated 16-bit bus memory slave with a mailbox word that raises an interrupt.
module dbus_mem
  import dbus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cyc,
  input  logic [STB_W-1:0]  i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_ack,
  output logic              o_int
);
  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so a window ending at the top of the address space cannot overflow.
  localparam logic [ADDR_W:0]  LIMIT   = {1'b0, ADDR_BASE} + (ADDR_W+1)'(2 * DEPTH);
  localparam logic [IDX_W-1:0] MBOX    = IDX_W'(DEPTH - 1);
  localparam logic [3:0]       WS_LOAD = 4'(WAIT_STATES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [STB_W-1:0]  r_stb;
  logic [DATA_W-1:0] r_dat;
  logic              r_int;

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hit;
  logic              w_accept;
  logic              w_wr;
  logic [DATA_W-1:0] w_rdat;

  assign w_off    = i_addr - ADDR_BASE;
  assign w_idx    = IDX_W'(w_off >> 1);
  assign w_hit    = ({1'b0, i_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, i_addr} < LIMIT);
  assign w_accept = (r_state == ST_IDLE) && i_cyc && (|i_stb) && w_hit;
  assign w_wr     = (r_state == ST_ACK) && r_we;

  dbus_mem_array #(.DEPTH(DEPTH)) u_array (
    .i_clk  (i_clk),
    .i_we   (w_wr),
    .i_be   (r_stb),
    .i_idx  (r_idx),
    .i_wdat (r_dat),
    .o_rdat (w_rdat)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_stb   <= '0;
      r_dat   <= '0;
      r_int   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx <= w_idx;
            r_we  <= i_we;
            r_stb <= i_stb;
            r_dat <= i_dat;
            if (WAIT_STATES == 0) begin
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WS_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!i_cyc)             r_state <= ST_IDLE;
          else if (r_cnt == 4'd0) r_state <= ST_ACK;
          else                    r_cnt   <= r_cnt - 4'd1;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          // Mailbox: a write raises the interrupt, a read acknowledges it.
          if (r_idx == MBOX) begin
            if (r_we && (|r_stb)) r_int <= 1'b1;
            else if (!r_we)       r_int <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack = (r_state == ST_ACK);
  assign o_dat = (o_ack && !r_we) ? w_rdat : '0;
  assign o_int = r_int;
endmodule

// File: tb/tb_dbus_mem.sv
// Directed scoreboard bench: one zero-wait instance at base 0, one 3-wait instance at base 0x100.
module tb_dbus_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc0 = 1'b0, cyc3 = 1'b0;
  logic [1:0]  stb = 2'b00;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [15:0] wdat = 16'h0;
  logic [15:0] dat0, dat3;
  logic        ack0, ack3, int0, int3;

  always #5 clk = ~clk;

  dbus_mem #(.ADDR_BASE(32'h0000_0000), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc0), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_dat(wdat), .o_dat(dat0), .o_ack(ack0), .o_int(int0));

  dbus_mem #(.ADDR_BASE(32'h0000_0100), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc3), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_dat(wdat), .o_dat(dat3), .o_ack(ack3), .o_int(int3));

  typedef struct {
    string       tag;
    logic        ack;
    logic [15:0] dat;
    logic        chk;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ack0 : ack3;
  endfunction

  function automatic logic [15:0] dat_of(input int sel);
    return (sel == 0) ? dat0 : dat3;
  endfunction

  // Drives one transfer from a posedge+1 point, holds it until ack or 20 cycles, then releases.
  task automatic xfer(input int sel, input logic we_i, input logic [1:0] stb_i,
                      input logic [31:0] a, input logic [15:0] d,
                      input logic exp_ack, input logic [15:0] exp_dat, input string tag);
    exp_t        e;
    int          k;
    logic        seen;
    logic [15:0] got;
    e.tag = tag; e.ack = exp_ack; e.dat = exp_dat;
    e.chk = exp_ack && !we_i;
    e.lat = 2 + ((sel == 0) ? 0 : 3);
    sb.push_back(e);
    we = we_i; stb = stb_i; addr = a; wdat = d;
    if (sel == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
    seen = 1'b0; k = 0; got = 16'h0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (ack_of(sel)) begin seen = 1'b1; got = dat_of(sel); end
    end
    e = sb.pop_front();
    check1({e.tag, "_ack"}, 32'(seen), 32'(e.ack));
    if (e.ack) check1({e.tag, "_lat"}, k, e.lat);
    if (e.chk) check1({e.tag, "_dat"}, 32'(got), 32'(e.dat));
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 2'b00; we = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic [12:0] mask;
    logic [15:0] got;
    int          acks;

    #2 rst_n = 1'b0;
    #1;
    check1("rst_ack0", 32'(ack0), 0);
    check1("rst_dat0", 32'(dat0), 0);
    check1("rst_int0", 32'(int0), 0);
    check1("rst_ack3", 32'(ack3), 0);
    check1("rst_dat3", 32'(dat3), 0);
    check1("rst_int3", 32'(int3), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait instance: preload, read, byte lanes.
    xfer(0, 1'b1, 2'b11, 32'd6,  16'hBEEF, 1'b1, 16'h0,    "wr_w3");
    xfer(0, 1'b0, 2'b11, 32'd6,  16'h0,    1'b1, 16'hBEEF, "rd_w3");
    check1("idle_dat0", 32'(dat0), 0);
    xfer(0, 1'b1, 2'b11, 32'd10, 16'h1234, 1'b1, 16'h0,    "wr_w5");
    xfer(0, 1'b1, 2'b10, 32'd10, 16'hAB00, 1'b1, 16'h0,    "wr_w5_hi");
    xfer(0, 1'b0, 2'b11, 32'd10, 16'h0,    1'b1, 16'hAB34, "rd_w5_hi");
    xfer(0, 1'b1, 2'b01, 32'd10, 16'hFFCD, 1'b1, 16'h0,    "wr_w5_lo");
    xfer(0, 1'b0, 2'b01, 32'd11, 16'h0,    1'b1, 16'hABCD, "rd_w5_odd");

    // No-strobe and out-of-window requests.
    xfer(0, 1'b0, 2'b00, 32'd6,  16'h0,    1'b0, 16'h0,    "nostb");
    xfer(0, 1'b0, 2'b11, 32'd32, 16'h0,    1'b0, 16'h0,    "miss_top");
    xfer(0, 1'b1, 2'b11, 32'd38, 16'h0000, 1'b0, 16'h0,    "miss_alias");
    xfer(0, 1'b0, 2'b11, 32'd6,  16'h0,    1'b1, 16'hBEEF, "rd_w3_after_miss");

    // Mailbox interrupt.
    xfer(0, 1'b1, 2'b11, 32'd30, 16'h0001, 1'b1, 16'h0,    "mbox_wr");
    check1("int_set", 32'(int0), 1);
    xfer(0, 1'b0, 2'b11, 32'd6,  16'h0,    1'b1, 16'hBEEF, "rd_other");
    check1("int_hold", 32'(int0), 1);
    xfer(0, 1'b0, 2'b11, 32'd30, 16'h0,    1'b1, 16'h0001, "mbox_rd");
    check1("int_clr", 32'(int0), 0);

    // Three-wait instance: latency and re-acceptance while held.
    xfer(3, 1'b1, 2'b11, 32'h102, 16'h4242, 1'b1, 16'h0,    "ws_wr");
    xfer(3, 1'b0, 2'b11, 32'h102, 16'h0,    1'b1, 16'h4242, "ws_rd");
    xfer(3, 1'b0, 2'b11, 32'h0FE, 16'h0,    1'b0, 16'h0,    "miss_low");

    e.tag = "hold"; e.ack = 1'b1; e.dat = 16'h4242; e.chk = 1'b1; e.lat = 32'h420;
    sb.push_back(e);
    mask = '0; got = 16'h0;
    we = 1'b0; stb = 2'b11; addr = 32'h102; cyc3 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack3) begin mask[k] = 1'b1; if (k == 5) got = dat3; end
    end
    @(posedge clk); #1;
    cyc3 = 1'b0; stb = 2'b00;
    e = sb.pop_front();
    check1({e.tag, "_mask"}, 32'(mask), e.lat);
    check1({e.tag, "_dat"}, 32'(got), 32'(e.dat));
    repeat (2) @(posedge clk);
    #1;

    // Abort a wait-stated write by dropping cyc.
    we = 1'b1; stb = 2'b11; addr = 32'h102; wdat = 16'h5555; cyc3 = 1'b1;
    @(posedge clk); #1;
    cyc3 = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack3) acks++;
    end
    check1("abort_noack", acks, 0);
    @(posedge clk); #1;
    we = 1'b0; stb = 2'b00;
    xfer(3, 1'b0, 2'b11, 32'h102, 16'h0, 1'b1, 16'h4242, "abort_rd");

    // Reset during WAIT.
    xfer(3, 1'b1, 2'b11, 32'h11E, 16'h0001, 1'b1, 16'h0, "mbox3_wr");
    check1("int3_set", 32'(int3), 1);
    xfer(3, 1'b1, 2'b11, 32'h104, 16'h1111, 1'b1, 16'h0, "w2_wr");
    we = 1'b1; stb = 2'b11; addr = 32'h104; wdat = 16'h7777; cyc3 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rstw_ack", 32'(ack3), 0);
    check1("rstw_int", 32'(int3), 0);
    check1("rstw_dat", 32'(dat3), 0);
    cyc3 = 1'b0; we = 1'b0; stb = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(3, 1'b0, 2'b11, 32'h104, 16'h0, 1'b1, 16'h1111, "rstw_rd");
    check1("rstw_int_after", 32'(int3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbus_mem.md
DBUS_MEM -- requirements
Module: dbus_mem

Interface
REQ-001 The block SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of 16-bit words (power of two, >=2).
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, meaning the number of extra cycles inserted before each ack (0..15).
REQ-004 Port i_clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port i_cyc, input, 1 bit: bus cycle in progress.
REQ-007 Port i_stb, input, 2 bits: byte-lane strobes; bit1 selects [15:8] and bit0 selects [7:0].
REQ-008 Port i_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port i_addr, input, 32 bits: byte address; bit 0 is ignored.
REQ-010 Port i_dat, input, 16 bits: write data.
REQ-011 Port o_dat, output, 16 bits: read data, valid while o_ack=1.
REQ-012 Port o_ack, output, 1 bit: one-cycle transfer-complete pulse.
REQ-013 Port o_int, output, 1 bit: mailbox interrupt; connects to the CPU's i_int.

Function
REQ-014 The window hit SHALL be ADDR_BASE <= i_addr < ADDR_BASE + 2*DEPTH; word index = (i_addr - ADDR_BASE) >> 1.
REQ-015 The FSM SHALL have states IDLE, WAIT and ACK.
REQ-016 A request SHALL be accepted in IDLE only when i_cyc=1, i_stb!=0 and the address is a window hit; on acceptance the block SHALL latch the word index, i_we, i_stb and i_dat.
REQ-017 On acceptance with WAIT_STATES=0, the FSM SHALL go to ACK; otherwise it SHALL go to WAIT with the counter loaded to WAIT_STATES-1.
REQ-018 WAIT SHALL decrement the counter each cycle and go to ACK when the counter is 0.
REQ-019 o_ack SHALL be 1 exactly in ACK; accepted in cycle N gives ack in cycle N+1+WAIT_STATES; ACK SHALL always return to IDLE.
REQ-020 Back-to-back requests therefore have at least one non-ack cycle between acks; a request still held in that IDLE cycle SHALL be accepted as a new transfer.
REQ-021 A write SHALL update only the strobed byte lanes of the latched word, committed at the clock edge ending ACK.
REQ-022 A read SHALL drive o_dat with the full latched word in ACK, independent of the strobes; o_dat SHALL be 0 outside ACK.
REQ-023 A miss, or i_stb=0, SHALL produce no ack and no state change; the block SHALL stay in IDLE.
REQ-024 If i_cyc falls in WAIT, the FSM SHALL abort to IDLE next cycle with no ack and no write.
REQ-025 Word DEPTH-1 is the mailbox; a write with any strobe SHALL set o_int=1 at the commit edge.
REQ-026 A read of word DEPTH-1 SHALL clear o_int at the ACK edge; o_int SHALL otherwise hold its value.
REQ-027 Memory reads and writes SHALL wrap only within the window; there SHALL be no aliasing outside it.

Reset
REQ-028 While i_reset_n=0, the block SHALL immediately force state=IDLE, o_ack=0, o_dat=0, o_int=0, counter=0 and the latches to 0.
REQ-029 A reset mid-transfer SHALL drop the transfer with no write; memory contents SHALL NOT be reset.
REQ-030 After reset deasserts, the first request SHALL be accepted on the first rising edge.

Structure
REQ-031 Shared package dbus_pkg SHALL hold the FSM state encoding, the strobe width (2), the data width (16) and the address width (32).
REQ-032 One sub-module, dbus_mem_array, SHALL implement the DEPTH x 16 byte-lane-writable synchronous array.

Verification
REQ-033 Zero-wait read: WAIT_STATES=0, preload word 3 = 16'hBEEF, read byte address 6, i_stb=2'b11 -> o_ack one cycle after acceptance with o_dat=16'hBEEF.
REQ-034 Byte-lane write: word 5 = 16'h1234, write 16'hAB00 with i_stb=2'b10 to byte address 10, then read it back -> 16'hAB34.
REQ-035 Wait states: WAIT_STATES=3, read at cycle N -> ack in cycle N+4 only, held cycles show no early ack, ACK->IDLE then re-accept.
REQ-036 Abort/miss: i_cyc dropped during WAIT on a write of 16'h5555 -> no ack and the word is unchanged; a request to ADDR_BASE+2*DEPTH -> no ack within 20 cycles.
REQ-037 Mailbox: write 16'h0001 to word DEPTH-1 -> o_int=1; a read of another word leaves it at 1; a read of DEPTH-1 -> o_int=0 after that ack.
REQ-038 Reset mid-WAIT: assert i_reset_n=0 asynchronously -> o_ack=0 and o_int=0 immediately, no write, and the next request is served normally.
